// File: rtl/piso_pkg.sv
// Shared definitions for the serializer/deserializer family: state encoding
// and the bit-counter width helper.
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Counter width for indices 0..width-1; a one-bit minimum keeps degenerate widths legal.
  function automatic int CNT_W(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter: a WIDTH-bit word accepted on valid/ready leaves one bit per shift_en.
// Latency: first bit on serial_out the cycle after acceptance; the frame spans exactly WIDTH shift_en pulses.
// Backpressure: in_ready only in IDLE or on the last bit with shift_en, which gives seamless back-to-back frames.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   LSB_FIRST  = 1'b0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             frame_last,
  output logic             busy
);

  localparam int            CW   = CNT_W(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
  logic             last_bit;

  assign last_bit = (state == ST_SHIFT) && (bit_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    in_ready    = (state == ST_IDLE) || (last_bit && shift_en);

    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          state_nxt   = ST_SHIFT;
          shreg_nxt   = in_data;
          bit_cnt_nxt = '0;
        end
      end
      ST_SHIFT: begin
        if (shift_en) begin
          if (!last_bit) begin
            // Move the next bit to the output end; vacated positions fill with 0.
            shreg_nxt   = LSB_FIRST ? {1'b0, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], 1'b0};
            bit_cnt_nxt = bit_cnt + CW'(1);
          end else if (in_valid) begin
            shreg_nxt   = in_data;
            bit_cnt_nxt = '0;
          end else begin
            state_nxt   = ST_IDLE;
            shreg_nxt   = '0;
            bit_cnt_nxt = '0;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bit_valid  = (state == ST_SHIFT);
  assign busy       = bit_valid;
  assign frame_last = last_bit;
  assign serial_out = bit_valid ? (LSB_FIRST ? shreg[0] : shreg[WIDTH-1]) : IDLE_LEVEL;

endmodule

// File: tb/tb_piso_serializer.sv
// Drives an MSB-first/idle-low and an LSB-first/idle-high serializer with shared stimulus,
// comparing every cycle against a bit-queue model of the frame.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       shift_en = 1'b0;

  logic rdy_m, ser_m, vld_m, last_m, busy_m;
  logic rdy_l, ser_l, vld_l, last_l, busy_l;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_m), .in_data(in_data),
    .shift_en(shift_en), .serial_out(ser_m), .bit_valid(vld_m), .frame_last(last_m), .busy(busy_m)
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_l), .in_data(in_data),
    .shift_en(shift_en), .serial_out(ser_l), .bit_valid(vld_l), .frame_last(last_l), .busy(busy_l)
  );

  int total = 0;
  int bad   = 0;

  // Model: the bits still owed on the wire, front element is the one currently driven.
  logic q_m[$];
  logic q_l[$];
  bit   chk_en = 1'b0;

  // Values seen at the most recent negedge.
  logic cap_ser_m, cap_ser_l, cap_vld_m, cap_last_m, cap_rdy_m;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d, input logic s);
    logic exp_busy, exp_rdy;
    rst = r; in_valid = v; in_data = d; shift_en = s;
    @(negedge clk);
    exp_busy = (q_m.size() != 0);
    exp_rdy  = !exp_busy || (q_m.size() == 1 && s);
    if (chk_en) begin
      check("ser_m",  {15'd0, ser_m},  {15'd0, exp_busy ? q_m[0] : 1'b0});
      check("ser_l",  {15'd0, ser_l},  {15'd0, exp_busy ? q_l[0] : 1'b1});
      check("vld_m",  {15'd0, vld_m},  {15'd0, exp_busy});
      check("vld_l",  {15'd0, vld_l},  {15'd0, exp_busy});
      check("busy_m", {15'd0, busy_m}, {15'd0, exp_busy});
      check("busy_l", {15'd0, busy_l}, {15'd0, exp_busy});
      check("last_m", {15'd0, last_m}, {15'd0, q_m.size() == 1});
      check("last_l", {15'd0, last_l}, {15'd0, q_l.size() == 1});
      check("rdy_m",  {15'd0, rdy_m},  {15'd0, exp_rdy});
      check("rdy_l",  {15'd0, rdy_l},  {15'd0, exp_rdy});
    end
    cap_ser_m = ser_m; cap_ser_l = ser_l; cap_vld_m = vld_m;
    cap_last_m = last_m; cap_rdy_m = rdy_m;
    @(posedge clk);
    if (r) begin
      q_m.delete();
      q_l.delete();
      chk_en = 1'b1;
    end else begin
      if (exp_busy && s) begin
        void'(q_m.pop_front());
        void'(q_l.pop_front());
      end
      if (v && exp_rdy) begin
        for (int i = 7; i >= 0; i--) q_m.push_back(d[i]);
        for (int i = 0; i < 8; i++)  q_l.push_back(d[i]);
      end
    end
    #1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_m;  // wire order, first bit in bit 7
    logic [7:0] exp_l;
  } vec_t;

  vec_t       tbl[5];
  logic [7:0] got_m, got_l;
  logic [15:0] got16;
  bit         dropped;

  initial begin
    tbl[0] = '{8'hA5, 8'hA5, 8'hA5};
    tbl[1] = '{8'hCC, 8'hCC, 8'h33};
    tbl[2] = '{8'h81, 8'h81, 8'h81};
    tbl[3] = '{8'hF0, 8'hF0, 8'h0F};
    tbl[4] = '{8'h12, 8'h12, 8'h48};

    // Reset held two cycles, then idle outputs.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("reset_ser_m", {15'd0, cap_ser_m}, 16'd0);
    check("reset_ser_l", {15'd0, cap_ser_l}, 16'd1);
    check("reset_vld",   {15'd0, cap_vld_m}, 16'd0);
    check("reset_rdy",   {15'd0, cap_rdy_m}, 16'd1);

    // Single frames, continuous shift_en.
    foreach (tbl[t]) begin
      step(1'b0, 1'b1, tbl[t].data, 1'b1);
      for (int k = 0; k < 8; k++) begin
        step(1'b0, 1'b0, 8'h00, 1'b1);
        got_m[7-k] = cap_ser_m;
        got_l[7-k] = cap_ser_l;
        if (k == 7) check("tbl_last", {15'd0, cap_last_m}, 16'd1);
      end
      check("tbl_bits_m", {8'd0, got_m}, {8'd0, tbl[t].exp_m});
      check("tbl_bits_l", {8'd0, got_l}, {8'd0, tbl[t].exp_l});
      step(1'b0, 1'b0, 8'h00, 1'b1);
      check("tbl_idle_after", {15'd0, cap_vld_m}, 16'd0);
    end

    // Back-to-back CC then F0 with in_valid held.
    step(1'b0, 1'b1, 8'hCC, 1'b1);
    dropped = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step(1'b0, (k <= 7), 8'hF0, 1'b1);
      got16[15-k] = cap_ser_m;
      if (!cap_vld_m) dropped = 1'b1;
    end
    check("b2b_bits", got16, 16'hCCF0);
    check("b2b_no_gap", {15'd0, dropped}, 16'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("b2b_idle_after", {15'd0, cap_vld_m}, 16'd0);

    // shift_en every 3rd cycle; the held second word waits for the 8th pulse.
    step(1'b0, 1'b1, 8'h81, 1'b0);
    for (int c = 0; c < 24; c++) begin
      step(1'b0, 1'b1, 8'h55, (c % 3 == 2));
      if (c % 3 == 2) got_m[7 - c/3] = cap_ser_m;
      check("slow_rdy", {15'd0, cap_rdy_m}, {15'd0, c == 23});
    end
    check("slow_bits", {8'd0, got_m}, 16'h0081);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      got_m[7-k] = cap_ser_m;
    end
    check("slow_second", {8'd0, got_m}, 16'h0055);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Reset after three bits of FF, then 0F sends cleanly.
    step(1'b0, 1'b1, 8'hFF, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b1, 8'h0F, 1'b1);
    step(1'b0, 1'b1, 8'h0F, 1'b1);
    check("abort_ser_m", {15'd0, cap_ser_m}, 16'd0);
    check("abort_ser_l", {15'd0, cap_ser_l}, 16'd1);
    check("abort_vld",   {15'd0, cap_vld_m}, 16'd0);
    check("abort_rdy",   {15'd0, cap_rdy_m}, 16'd1);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      got_m[7-k] = cap_ser_m;
      got_l[7-k] = cap_ser_l;
    end
    check("abort_new_m", {8'd0, got_m}, 16'h000F);
    check("abort_new_l", {8'd0, got_l}, 16'h00F0);

    // Randomised traffic against the queue model.
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0),
           8'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
